mul_div_unit: RTL and testbench

- Multi-cycle multiply/divide unit in the EX stage, beside the ALU.
- Takes the same SrcA/SrcB operands as the ALU and holds results in its own HI/LO registers.
- HI/LO feed the writeback mux for mfhi/mflo.
- Busy output tells the hazard unit to stall dependent instructions.

---
 rtl/mul_div_unit.sv | 198 +++++++++++++++++++
 tb/tb_mul_div_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle multiply/divide unit sitting beside the ALU in EX.
// Owns the HI/LO registers. Busy stalls dependent instructions while a
// mult/multu/div/divu is in flight; mthi/mtlo complete in one cycle.
// Results are formed combinationally from the latched operands; the counter
// only models the latency.
module mul_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  MDUOp,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MaxCycles = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CntW      = $clog2(MaxCycles + 1);

  localparam logic [CntW-1:0] multLoad = CntW'(MULT_CYCLES);
  localparam logic [CntW-1:0] divLoad  = CntW'(DIV_CYCLES);
  localparam logic [CntW-1:0] cntOne   = CntW'(1);

  localparam logic [2:0] opMthi = 3'b100;
  localparam logic [2:0] opMtlo = 3'b101;

  typedef enum logic {
    sIdle = 1'b0,
    sBusy = 1'b1
  } stateT;

  stateT            stateReg;
  stateT            stateNext;
  logic [CntW-1:0]  countReg;
  logic [1:0]       opReg;      // long ops are 0xx, so the low two bits identify them
  logic [31:0]      aReg;
  logic [31:0]      bReg;

  logic             accept;
  logic             launchLong;
  logic             writeResult;
  logic             writeHi;
  logic             writeLo;

  logic [63:0]      prodSigned;
  logic [63:0]      prodUnsigned;
  logic             aNeg;
  logic             bNeg;
  logic [31:0]      aMag;
  logic [31:0]      bMag;
  logic [31:0]      divA;
  logic [31:0]      divB;
  logic [31:0]      divQ;
  logic [31:0]      divR;
  logic             divByZero;
  logic [31:0]      resHi;
  logic [31:0]      resLo;

  // A request is only honoured while idle; a Start during Busy is dropped.
  assign accept     = Start && (stateReg == sIdle);
  assign launchLong = accept && (MDUOp[2] == 1'b0);

  // State register; Busy is registered alongside so it mirrors the state bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg <= sIdle;
      Busy     <= 1'b0;
    end else begin
      stateReg <= stateNext;
      Busy     <= (stateNext == sBusy);
    end
  end

  // Next-state: go busy on a long-op launch, return idle after the last Busy cycle.
  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      sIdle: begin
        if (launchLong) stateNext = sBusy;
        else            stateNext = sIdle;
      end
      sBusy: begin
        if (countReg == cntOne) stateNext = sIdle;
        else                    stateNext = sBusy;
      end
      default: stateNext = sIdle;
    endcase
  end

  // FSM outputs: result commit at the edge ending the last Busy cycle, plus mthi/mtlo strobes.
  always_comb begin
    writeResult = 1'b0;
    writeHi     = 1'b0;
    writeLo     = 1'b0;
    case (stateReg)
      sBusy: begin
        if ((countReg == cntOne) && !divByZero) writeResult = 1'b1;
        else                                    writeResult = 1'b0;
      end
      sIdle: begin
        if (accept && (MDUOp == opMthi)) writeHi = 1'b1;
        else                             writeHi = 1'b0;
        if (accept && (MDUOp == opMtlo)) writeLo = 1'b1;
        else                             writeLo = 1'b0;
      end
      default: begin
        writeResult = 1'b0;
        writeHi     = 1'b0;
        writeLo     = 1'b0;
      end
    endcase
  end

  // Latch operands/op at launch and count down the latency while busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      countReg <= '0;
      opReg    <= 2'b00;
      aReg     <= 32'd0;
      bReg     <= 32'd0;
    end else if (launchLong) begin
      countReg <= MDUOp[1] ? divLoad : multLoad;
      opReg    <= MDUOp[1:0];
      aReg     <= SrcA;
      bReg     <= SrcB;
    end else if (stateReg == sBusy) begin
      countReg <= countReg - cntOne;
    end
  end

  // Arithmetic on latched operands; one shared unsigned divider serves div and divu.
  always_comb begin
    prodUnsigned = {32'd0, aReg} * {32'd0, bReg};
    prodSigned   = {{32{aReg[31]}}, aReg} * {{32{bReg[31]}}, bReg};
    aNeg         = aReg[31];
    bNeg         = bReg[31];
    aMag         = aNeg ? (32'd0 - aReg) : aReg;
    bMag         = bNeg ? (32'd0 - bReg) : bReg;
    divByZero    = opReg[1] && (bReg == 32'd0);
    if (opReg[0]) begin
      divA = aReg;
      divB = bReg;
    end else begin
      divA = aMag;
      divB = bMag;
    end
    // Divisor of zero never commits; substitute 1 to keep the divider well defined.
    if (divB == 32'd0) begin
      divQ = divA;
      divR = 32'd0;
    end else begin
      divQ = divA / divB;
      divR = divA % divB;
    end
    case (opReg)
      2'b00: begin
        resHi = prodSigned[63:32];
        resLo = prodSigned[31:0];
      end
      2'b01: begin
        resHi = prodUnsigned[63:32];
        resLo = prodUnsigned[31:0];
      end
      2'b10: begin
        // Quotient truncates toward zero; remainder follows the dividend's sign.
        resLo = (aNeg ^ bNeg) ? (32'd0 - divQ) : divQ;
        resHi = aNeg ? (32'd0 - divR) : divR;
      end
      2'b11: begin
        resHi = divR;
        resLo = divQ;
      end
      default: begin
        resHi = 32'd0;
        resLo = 32'd0;
      end
    endcase
  end

  // HI/LO update: long-op commit, or single-cycle mthi/mtlo.
  always_ff @(posedge clk) begin
    if (reset) begin
      HI <= 32'd0;
      LO <= 32'd0;
    end else if (writeResult) begin
      HI <= resHi;
      LO <= resLo;
    end else begin
      if (writeHi) HI <= SrcA;
      if (writeLo) LO <= SrcA;
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed scenarios plus randomized
// operations checked against a cycle-level reference model of HI/LO/Busy.
module tb_mul_div_unit;

  localparam int MultN = 5;
  localparam int DivN  = 10;

  logic        clk;
  logic        reset;
  logic        Start;
  logic [2:0]  MDUOp;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks;
  int errors;

  logic [31:0] modelHi;
  logic [31:0] modelLo;

  mul_div_unit #(.MULT_CYCLES(MultN), .DIV_CYCLES(DivN)) dut (
    .clk   (clk),
    .reset (reset),
    .Start (Start),
    .MDUOp (MDUOp),
    .SrcA  (SrcA),
    .SrcB  (SrcB),
    .Busy  (Busy),
    .HI    (HI),
    .LO    (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference result from plain 64-bit arithmetic.
  function automatic void refResult(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                    input logic [31:0] hiIn, input logic [31:0] loIn,
                                    output logic [31:0] hiOut, output logic [31:0] loOut);
    longint sa, sb, p, q, r;
    longint unsigned ua, ub, pu;
    hiOut = hiIn;
    loOut = loIn;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = 64'(a);
    ub = 64'(b);
    case (op)
      3'd0: begin p = sa * sb; hiOut = p[63:32]; loOut = p[31:0]; end
      3'd1: begin pu = ua * ub; hiOut = pu[63:32]; loOut = pu[31:0]; end
      3'd2: if (b != 32'd0) begin q = sa / sb; r = sa % sb; hiOut = r[31:0]; loOut = q[31:0]; end
      3'd3: if (b != 32'd0) begin hiOut = a % b; loOut = a / b; end
      3'd4: hiOut = a;
      3'd5: loOut = a;
      default: ;
    endcase
  endfunction

  // Present a request for one edge; returns #1 after the accepting edge with operands scrambled.
  task automatic doStart(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    Start = 1'b1; MDUOp = op; SrcA = a; SrcB = b;
    @(posedge clk);
    #1;
    Start = 1'b0; SrcA = $urandom; SrcB = $urandom; MDUOp = 3'($urandom_range(0, 7));
  endtask

  // Issue one op and check the Busy window and HI/LO each cycle against the model.
  task automatic runOp(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] expHi, expLo;
    int n;
    refResult(op, a, b, modelHi, modelLo, expHi, expLo);
    n = op[1] ? DivN : MultN;
    doStart(op, a, b);
    if (op[2] == 1'b0) begin
      for (int k = 1; k <= n; k++) begin
        if (k > 1) begin @(posedge clk); #1; end
        checks++;
        if (Busy !== 1'b1) begin errors++; $display("FAIL %s busy cycle %0d: Busy=%b expected 1", name, k, Busy); end
        checks++;
        if (HI !== modelHi || LO !== modelLo) begin
          errors++; $display("FAIL %s hold cycle %0d: HI=%h LO=%h expected HI=%h LO=%h", name, k, HI, LO, modelHi, modelLo);
        end
      end
      @(posedge clk); #1;
    end
    modelHi = expHi;
    modelLo = expLo;
    checks++;
    if (Busy !== 1'b0) begin errors++; $display("FAIL %s done: Busy=%b expected 0", name, Busy); end
    checks++;
    if (HI !== modelHi || LO !== modelLo) begin
      errors++; $display("FAIL %s result: HI=%h LO=%h expected HI=%h LO=%h", name, HI, LO, modelHi, modelLo);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; Start = 1'b0; MDUOp = 3'd0; SrcA = 32'd0; SrcB = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    modelHi = 32'd0; modelLo = 32'd0;
    checks++;
    if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
      errors++; $display("FAIL reset: Busy=%b HI=%h LO=%h expected 0/0/0", Busy, HI, LO);
    end
  endtask

  task automatic test_mult();
    runOp("mult", 3'd0, 32'hFFFF_FFFF, 32'd2);
    checks++;
    if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFE) begin
      errors++; $display("FAIL mult const: HI=%h LO=%h expected ffffffff/fffffffe", HI, LO);
    end
    runOp("multu", 3'd1, 32'hFFFF_FFFF, 32'd2);
    checks++;
    if (HI !== 32'h0000_0001 || LO !== 32'hFFFF_FFFE) begin
      errors++; $display("FAIL multu const: HI=%h LO=%h expected 00000001/fffffffe", HI, LO);
    end
  endtask

  task automatic test_div();
    runOp("div", 3'd2, 32'hFFFF_FFF9, 32'd2);
    checks++;
    if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFD) begin
      errors++; $display("FAIL div const: HI=%h LO=%h expected ffffffff/fffffffd", HI, LO);
    end
    runOp("divu", 3'd3, 32'd7, 32'd2);
    checks++;
    if (HI !== 32'd1 || LO !== 32'd3) begin
      errors++; $display("FAIL divu const: HI=%h LO=%h expected 1/3", HI, LO);
    end
    runOp("div overflow", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    checks++;
    if (HI !== 32'd0 || LO !== 32'h8000_0000) begin
      errors++; $display("FAIL div overflow const: HI=%h LO=%h expected 0/80000000", HI, LO);
    end
    runOp("div neg divisor", 3'd2, 32'd7, 32'hFFFF_FFFE);
  endtask

  task automatic test_div_zero();
    runOp("mthi preset", 3'd4, 32'h11, 32'd0);
    runOp("mtlo preset", 3'd5, 32'h22, 32'd0);
    runOp("div by zero", 3'd2, 32'h1234_5678, 32'd0);
    runOp("divu by zero", 3'd3, 32'hFFFF_FFFF, 32'd0);
    checks++;
    if (HI !== 32'h11 || LO !== 32'h22) begin
      errors++; $display("FAIL div zero const: HI=%h LO=%h expected 11/22", HI, LO);
    end
  endtask

  task automatic test_mthi_mtlo();
    runOp("mthi", 3'd4, 32'hDEAD_BEEF, 32'd5);
    checks++;
    if (HI !== 32'hDEAD_BEEF || LO !== 32'h22) begin
      errors++; $display("FAIL mthi const: HI=%h LO=%h expected deadbeef/22", HI, LO);
    end
    runOp("mtlo", 3'd5, 32'hCAFE_F00D, 32'd5);
    runOp("undef 110", 3'd6, 32'h1111_1111, 32'h2222_2222);
    runOp("undef 111", 3'd7, 32'h3333_3333, 32'h4444_4444);
  endtask

  task automatic test_start_during_busy();
    logic [31:0] expHi, expLo;
    refResult(3'd0, 32'h0001_0003, 32'hFFFF_FFF0, modelHi, modelLo, expHi, expLo);
    doStart(3'd0, 32'h0001_0003, 32'hFFFF_FFF0);
    for (int k = 1; k <= MultN; k++) begin
      if (k > 1) begin @(posedge clk); #1; Start = 1'b0; end
      checks++;
      if (Busy !== 1'b1 || HI !== modelHi || LO !== modelLo) begin
        errors++; $display("FAIL busy ignore cycle %0d: Busy=%b HI=%h LO=%h expected 1 %h %h", k, Busy, HI, LO, modelHi, modelLo);
      end
      if (k == 2) begin Start = 1'b1; MDUOp = 3'd2; SrcA = 32'd100; SrcB = 32'd7; end
    end
    @(posedge clk); #1;
    modelHi = expHi; modelLo = expLo;
    for (int k = 0; k < DivN + 2; k++) begin
      checks++;
      if (Busy !== 1'b0 || HI !== modelHi || LO !== modelLo) begin
        errors++; $display("FAIL busy ignore after %0d: Busy=%b HI=%h LO=%h expected 0 %h %h", k, Busy, HI, LO, modelHi, modelLo);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_op();
    runOp("pre mthi", 3'd4, 32'hA5A5_0001, 32'd0);
    doStart(3'd1, 32'h0000_1234, 32'h0000_5678);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    checks++;
    if (Busy !== 1'b1) begin errors++; $display("FAIL reset mid busy3: Busy=%b expected 1", Busy); end
    @(posedge clk); #1;
    reset = 1'b0;
    modelHi = 32'd0; modelLo = 32'd0;
    for (int k = 0; k < MultN + 3; k++) begin
      checks++;
      if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
        errors++; $display("FAIL reset mid after %0d: Busy=%b HI=%h LO=%h expected 0/0/0", k, Busy, HI, LO);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'($urandom_range(0, 2));
        1: b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 4) == 0) a = 32'h8000_0000;
      runOp("random", op, a, b);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    modelHi = 32'd0;
    modelLo = 32'd0;
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_mthi_mtlo();
    test_start_during_busy();
    test_reset_mid_op();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
